// File: rtl/vga_scan_driver.sv
// Raster-order VGA timing generator: pixel coordinates out, game colour in,
// registered sync and blanking-gated colour to the pins, one-clk frame strobe.
module vga_scan_driver #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_red,
  input  logic        vga_green,
  input  logic        vga_blue,
  output logic [10:0] vga_xpos,
  output logic [9:0]  vga_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_r_o,
  output logic        vga_g_o,
  output logic        vga_b_o,
  output logic        vga_de,
  output logic        frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_check
    $error("vga_scan_driver: CLK_DIV must be >= 1 and totals must fit in 11/10 bits");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [10:0]      h_cnt;
  logic [9:0]       v_cnt;
  logic             pix_tick;
  logic             line_end;
  logic             frame_end;
  logic             active;
  logic             hs_on;
  logic             vs_on;

  // With CLK_DIV=1 the divider sits at 0 and every clk is a pixel tick.
  assign pix_tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign line_end  = (h_cnt == 11'(H_TOTAL - 1));
  assign frame_end = (v_cnt == 10'(V_TOTAL - 1));
  assign active    = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs_on     = (h_cnt >= 11'(HS_START)) && (h_cnt < 11'(HS_END));
  assign vs_on     = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));

  assign vga_xpos    = h_cnt;
  assign vga_ypos    = v_cnt;
  assign frame_start = pix_tick && (h_cnt == 11'd0) && (v_cnt == 10'd0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      if (pix_tick) begin
        if (line_end) begin
          h_cnt <= '0;
          v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Pin stage lags the coordinates by one pixel tick; colour is the game's
  // answer for the coordinate presented during that tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs  <= ~SYNC_POL;
      vga_vs  <= ~SYNC_POL;
      vga_de  <= 1'b0;
      vga_r_o <= 1'b0;
      vga_g_o <= 1'b0;
      vga_b_o <= 1'b0;
    end else if (pix_tick) begin
      vga_hs  <= hs_on ? SYNC_POL : ~SYNC_POL;
      vga_vs  <= vs_on ? SYNC_POL : ~SYNC_POL;
      vga_de  <= active;
      vga_r_o <= vga_red & active;
      vga_g_o <= vga_green & active;
      vga_b_o <= vga_blue & active;
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: full-size timing instance plus two shrunken
// geometries (CLK_DIV=1 active-low, CLK_DIV=3 active-high) so whole frames fit.
module tb_vga_scan_driver;
  typedef struct {
    int   ha, hfp, hsy, hbp, va, vfp, vsy, vbp, div;
    logic pol;
  } geom_t;

  typedef struct {
    int   n;
    int   x;
    int   y;
    logic hs;
    logic de;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       red;
  logic [2:0]       green;
  logic [2:0]       blue;
  logic [2:0][10:0] xpos;
  logic [2:0][9:0]  ypos;
  logic [2:0]       hs;
  logic [2:0]       vs;
  logic [2:0]       r_o;
  logic [2:0]       g_o;
  logic [2:0]       b_o;
  logic [2:0]       de;
  logic [2:0]       fs;

  vga_scan_driver u_dut0 (
    .clk(clk), .rst(rst[0]), .vga_red(red[0]), .vga_green(green[0]), .vga_blue(blue[0]),
    .vga_xpos(xpos[0]), .vga_ypos(ypos[0]), .vga_hs(hs[0]), .vga_vs(vs[0]),
    .vga_r_o(r_o[0]), .vga_g_o(g_o[0]), .vga_b_o(b_o[0]), .vga_de(de[0]),
    .frame_start(fs[0])
  );

  vga_scan_driver #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]), .vga_red(red[1]), .vga_green(green[1]), .vga_blue(blue[1]),
    .vga_xpos(xpos[1]), .vga_ypos(ypos[1]), .vga_hs(hs[1]), .vga_vs(vs[1]),
    .vga_r_o(r_o[1]), .vga_g_o(g_o[1]), .vga_b_o(b_o[1]), .vga_de(de[1]),
    .frame_start(fs[1])
  );

  vga_scan_driver #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_dut2 (
    .clk(clk), .rst(rst[2]), .vga_red(red[2]), .vga_green(green[2]), .vga_blue(blue[2]),
    .vga_xpos(xpos[2]), .vga_ypos(ypos[2]), .vga_hs(hs[2]), .vga_vs(vs[2]),
    .vga_r_o(r_o[2]), .vga_g_o(g_o[2]), .vga_b_o(b_o[2]), .vga_de(de[2]),
    .frame_start(fs[2])
  );

  int         total = 0;
  int         bad = 0;
  logic [5:0] exp_q[$];
  int         kc[3];
  int         nt[3];
  int         fs_prev[3];
  int         hs_cnt[3];
  int         vs_cnt[3];
  int         cmode = 0;
  vec_t       vecs[12];

  function automatic geom_t geom(input int s);
    geom_t gm;
    if (s == 0) gm = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    else        gm = '{8, 2, 3, 2, 6, 1, 2, 1, (s == 1) ? 1 : 3, logic'(s == 2)};
    return gm;
  endfunction

  // Pin values {hs, vs, de, r, g, b} expected one tick after pixel (x, y).
  function automatic logic [5:0] model_pins(input int s, input int x, input int y,
                                            input logic cr, input logic cg, input logic cb);
    geom_t gm = geom(s);
    logic  act, hon, von;
    act = (x < gm.ha) && (y < gm.va);
    hon = (x >= gm.ha + gm.hfp) && (x < gm.ha + gm.hfp + gm.hsy);
    von = (y >= gm.va + gm.vfp) && (y < gm.va + gm.vfp + gm.vsy);
    return {hon ? gm.pol : ~gm.pol, von ? gm.pol : ~gm.pol, act, cr & act, cg & act, cb & act};
  endfunction

  task automatic check(input string name, input int s, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d tick%0d: got %0d want %0d", name, s, nt[s], act, exp);
    end
  endtask

  task automatic drive_colour(input int s);
    if (cmode == 1) {red[s], green[s], blue[s]} = 3'b100;
    else            {red[s], green[s], blue[s]} = 3'($urandom_range(0, 7));
  endtask

  // One clk of instance s: frame_start every clk, coordinates and the popped
  // pin expectation on tick clks, then new colour and a pushed expectation.
  task automatic step(input int s, output logic tk);
    geom_t      gm = geom(s);
    int         ht = gm.ha + gm.hfp + gm.hsy + gm.hbp;
    int         vt = gm.va + gm.vfp + gm.vsy + gm.vbp;
    int         ex = nt[s] % ht;
    int         ey = (nt[s] / ht) % vt;
    logic [5:0] got;
    tk  = (kc[s] % gm.div) == gm.div - 1;
    got = {hs[s], vs[s], de[s], r_o[s], g_o[s], b_o[s]};
    check("frame_start", s, int'(fs[s]), int'(tk && ex == 0 && ey == 0));
    if (fs[s]) begin
      if (fs_prev[s] >= 0) check("fs_period_clks", s, kc[s] - fs_prev[s], ht * vt * gm.div);
      fs_prev[s] = kc[s];
    end
    if (tk) begin
      check("xpos", s, int'(xpos[s]), ex);
      check("ypos", s, int'(ypos[s]), ey);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pin_queue dut%0d tick%0d: got empty want entry", s, nt[s]);
      end else begin
        check("pins_hs_vs_de_rgb", s, int'(got), int'(exp_q.pop_front()));
      end
      if (got[5] == gm.pol) hs_cnt[s]++;
      if (got[4] == gm.pol) vs_cnt[s]++;
    end
    drive_colour(s);
    if (tk) begin
      exp_q.push_back(model_pins(s, ex, ey, red[s], green[s], blue[s]));
      nt[s]++;
    end
  endtask

  task automatic run_ticks(input int s, input int n);
    int   done = 0;
    int   guard = 0;
    logic tk;
    while (done < n) begin
      if (guard > n * 4 + 10) begin
        total++;
        bad++;
        $display("FAIL tick_budget dut%0d: got %0d ticks want %0d", s, done, n);
        return;
      end
      @(negedge clk);
      guard++;
      kc[s]++;
      step(s, tk);
      if (tk) done++;
    end
  endtask

  // Called on a negedge; the release cycle itself is processed as cycle 0.
  task automatic do_reset(input int s, input int cyc);
    geom_t gm = geom(s);
    logic  tk;
    rst[s] = 1'b1;
    repeat (cyc) begin
      drive_colour(s);
      @(negedge clk);
    end
    check("rst_xpos", s, int'(xpos[s]), 0);
    check("rst_ypos", s, int'(ypos[s]), 0);
    check("rst_frame_start", s, int'(fs[s]), 0);
    check("rst_pins", s, int'({hs[s], vs[s], de[s], r_o[s], g_o[s], b_o[s]}),
          int'({~gm.pol, ~gm.pol, 4'b0000}));
    rst[s]     = 1'b0;
    kc[s]      = 0;
    nt[s]      = 0;
    fs_prev[s] = -1;
    hs_cnt[s]  = 0;
    vs_cnt[s]  = 0;
    exp_q.delete();
    exp_q.push_back({~gm.pol, ~gm.pol, 4'b0000});
    #1;
    step(s, tk);
  endtask

  initial begin
    rst   = 3'b111;
    red   = '0;
    green = '0;
    blue  = '0;
    // tick index, xpos, ypos at that tick, pins for the previous pixel
    vecs[0]  = '{0,    0,   0, 1'b1, 1'b0};
    vecs[1]  = '{1,    1,   0, 1'b1, 1'b1};
    vecs[2]  = '{640,  640, 0, 1'b1, 1'b1};
    vecs[3]  = '{641,  641, 0, 1'b1, 1'b0};
    vecs[4]  = '{656,  656, 0, 1'b1, 1'b0};
    vecs[5]  = '{657,  657, 0, 1'b0, 1'b0};
    vecs[6]  = '{752,  752, 0, 1'b0, 1'b0};
    vecs[7]  = '{753,  753, 0, 1'b1, 1'b0};
    vecs[8]  = '{800,  0,   1, 1'b1, 1'b0};
    vecs[9]  = '{801,  1,   1, 1'b1, 1'b1};
    vecs[10] = '{1600, 0,   2, 1'b1, 1'b0};
    vecs[11] = '{2399, 799, 2, 1'b1, 1'b0};
    @(negedge clk);

    // Full-size timing: horizontal landmarks, hsync width, mid-line reset.
    do_reset(0, 2);
    for (int i = 0; i < 12; i++) begin
      run_ticks(0, vecs[i].n + 1 - nt[0]);
      check("tbl_xpos", 0, int'(xpos[0]), vecs[i].x);
      check("tbl_ypos", 0, int'(ypos[0]), vecs[i].y);
      check("tbl_hs", 0, int'(hs[0]), int'(vecs[i].hs));
      check("tbl_de", 0, int'(de[0]), int'(vecs[i].de));
    end
    check("hs_low_ticks_3_lines", 0, hs_cnt[0], 288);
    check("vs_low_ticks_3_lines", 0, vs_cnt[0], 0);
    run_ticks(0, 301);
    check("pre_rst_xpos", 0, int'(xpos[0]), 300);
    check("pre_rst_ypos", 0, int'(ypos[0]), 3);
    do_reset(0, 1);
    run_ticks(0, 810);

    // CLK_DIV=1, active-low: red held for one frame, then random colour.
    do_reset(1, 3);
    cmode = 1;
    run_ticks(1, 149);
    check("hs_low_ticks_frame", 1, hs_cnt[1], 30);
    check("vs_low_ticks_frame", 1, vs_cnt[1], 30);
    cmode = 0;
    run_ticks(1, 200);
    check("pre_rst_ypos", 1, int'(ypos[1]), 3);
    do_reset(1, 1);
    run_ticks(1, 160);

    // CLK_DIV=3, active-high sync.
    do_reset(2, 2);
    run_ticks(2, 150);
    check("hs_high_ticks_frame", 2, hs_cnt[2], 30);
    check("vs_high_ticks_frame", 2, vs_cnt[2], 30);
    run_ticks(2, 171);
    do_reset(2, 1);
    run_ticks(2, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
